// File: rtl/regfile_access_ctrl.sv
// rtl/regfile_access_ctrl.sv - command-driven initiator for the 32x32 register file
// One command in flight: IDLE accepts, EXEC drives the file for one cycle, RESP holds the result.
module regfile_access_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [4:0]  cmd_rd,
    input  logic [31:0] cmd_wdata,
    output logic [4:0]  read_reg1,
    output logic [4:0]  read_reg2,
    input  logic [31:0] read_data1,
    input  logic [31:0] read_data2,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        reg_write,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data1,
    output logic [31:0] rsp_data2,
    output logic [15:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_READ2 = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_ADD   = 2'b11;

    state_t      state_q;
    logic [1:0]  op_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data1_q;
    logic [31:0] rsp_data2_q;
    logic [15:0] op_count_q;

    logic [32:0] sum_d;
    logic [31:0] wval_d;
    logic [31:0] data1_d;
    logic [31:0] data2_d;
    logic        exec_live;

    // Results come straight off the file's combinational read ports during EXEC.
    always_comb begin
        sum_d  = {1'b0, read_data1} + {1'b0, read_data2};
        wval_d = read_data1;
        case (op_q)
            OP_WRITE: wval_d = wdata_q;
            OP_COPY:  wval_d = read_data1;
            OP_ADD:   wval_d = sum_d[31:0];
            default:  wval_d = read_data1;
        endcase

        data1_d = wval_d;
        data2_d = 32'd0;
        if (op_q == OP_READ2) begin
            data1_d = read_data1;
            data2_d = read_data2;
        end else if (op_q == OP_ADD) begin
            data2_d = {31'd0, sum_d[32]};
        end
    end

    assign exec_live  = reset_n && (state_q == EXEC);
    assign reg_write  = exec_live && (op_q != OP_READ2) && (rd_q != 5'd0);
    assign write_data = exec_live ? wval_d : 32'd0;
    assign write_reg  = rd_q;
    assign read_reg1  = rs1_q;
    assign read_reg2  = rs2_q;
    assign cmd_ready  = reset_n && (state_q == IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data1  = rsp_data1_q;
    assign rsp_data2  = rsp_data2_q;
    assign op_count   = op_count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= OP_READ2;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_data1_q <= 32'd0;
            rsp_data2_q <= 32'd0;
            op_count_q  <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        rs1_q   <= cmd_rs1;
                        rs2_q   <= cmd_rs2;
                        rd_q    <= cmd_rd;
                        wdata_q <= cmd_wdata;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data1_q <= data1_d;
                    rsp_data2_q <= data2_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb/tb_regfile_access_ctrl.sv - scoreboard bench for regfile_access_ctrl with a behavioural register file
module tb_regfile_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rs1;
    logic [4:0]  cmd_rs2;
    logic [4:0]  cmd_rd;
    logic [31:0] cmd_wdata;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data1;
    logic [31:0] rsp_data2;
    logic [15:0] op_count;

    localparam logic [1:0] RD2 = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] CPY = 2'b10;
    localparam logic [1:0] ADD = 2'b11;

    int vectors     = 0;
    int miscompares = 0;
    int wr_count    = 0;
    int exp_ops     = 0;
    logic [63:0] sb_q[$];
    logic [31:0] rf[32];

    regfile_access_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd), .cmd_wdata(cmd_wdata),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data1(rsp_data1), .rsp_data2(rsp_data2), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational reads, posedge writes, r0 hard-wired to zero.
    assign read_data1 = (read_reg1 == 5'd0) ? 32'd0 : rf[read_reg1];
    assign read_data2 = (read_reg2 == 5'd0) ? 32'd0 : rf[read_reg2];
    always @(posedge clk) begin
        if (reg_write) begin
            wr_count = wr_count + 1;
            if (write_reg != 5'd0) rf[write_reg] <= write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                chk("rsp_data1", rsp_data1, e[63:32]);
                chk("rsp_data2", rsp_data2, e[31:0]);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] wd,
                         input logic [31:0] exp1, input logic [31:0] exp2, input logic exp_we);
        int b;
        int wc0;
        b = 0;
        @(negedge clk);
        cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        chk("accept_timeout", (b < 50) ? 32'd1 : 32'd0, 32'd1);
        sb_q.push_back({exp1, exp2});
        wc0 = wr_count;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("exec_reg_write", reg_write, exp_we);
        chk("exec_cmd_ready", cmd_ready, 32'd0);
        chk("exec_rsp_valid", rsp_valid, 32'd0);
        chk("exec_read_reg1", read_reg1, rs1);
        chk("exec_read_reg2", read_reg2, rs2);
        if (op != RD2) begin
            chk("exec_write_reg", write_reg, rd);
            chk("exec_write_data", write_data, exp1);
        end
        @(negedge clk);
        chk("resp_rsp_valid", rsp_valid, 32'd1);
        chk("resp_reg_write", reg_write, 32'd0);
        chk("resp_cmd_ready", cmd_ready, 32'd0);
        chk("write_pulses", wr_count - wc0, exp_we ? 32'd1 : 32'd0);
    endtask

    task automatic run(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] wd,
                       input logic [31:0] exp1, input logic [31:0] exp2, input logic exp_we);
        int b;
        b = 0;
        issue(op, rs1, rs2, rd, wd, exp1, exp2, exp_we);
        while (!cmd_ready && b < 20) begin
            @(negedge clk);
            b++;
        end
        chk("back_to_idle_cycles", b, 32'd1);
        exp_ops++;
    endtask

    initial begin
        int wc0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        cmd_op = RD2; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_rd = 5'd0; cmd_wdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_op_count", op_count, 32'd0);
        chk("rst_reg_write", reg_write, 32'd0);
        chk("rst_rsp_data1", rsp_data1, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 32'd1);

        run(WR,  5'd0,  5'd0,  5'd5,  32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 1'b1);
        run(RD2, 5'd5,  5'd0,  5'd0,  32'h0,        32'hAABBCCDD, 32'h0, 1'b0);
        chk("op_count_2", op_count, 32'd2);

        run(WR,  5'd0,  5'd0,  5'd10, 32'h11223344, 32'h11223344, 32'h0, 1'b1);
        run(ADD, 5'd5,  5'd10, 5'd7,  32'h0,        32'hBBDE0021, 32'h0, 1'b1);
        run(WR,  5'd0,  5'd0,  5'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
        run(WR,  5'd0,  5'd0,  5'd2,  32'h00000001, 32'h00000001, 32'h0, 1'b1);
        run(ADD, 5'd1,  5'd2,  5'd3,  32'h0,        32'h00000000, 32'h1, 1'b1);
        run(RD2, 5'd3,  5'd7,  5'd0,  32'h0,        32'h00000000, 32'hBBDE0021, 1'b0);

        run(WR,  5'd0,  5'd0,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0);
        run(RD2, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0, 1'b0);

        run(CPY, 5'd5,  5'd0,  5'd15, 32'h0,        32'hAABBCCDD, 32'h0, 1'b1);
        run(RD2, 5'd15, 5'd5,  5'd0,  32'h0,        32'hAABBCCDD, 32'hAABBCCDD, 1'b0);
        run(CPY, 5'd5,  5'd0,  5'd5,  32'h0,        32'hAABBCCDD, 32'h0, 1'b1);
        run(RD2, 5'd5,  5'd15, 5'd0,  32'h0,        32'hAABBCCDD, 32'hAABBCCDD, 1'b0);
        chk("op_count_14", op_count, exp_ops);

        // Backpressure: response held 5 cycles while a second command waits.
        rsp_ready = 1'b0;
        issue(ADD, 5'd10, 5'd5, 5'd20, 32'h0, 32'hBBDE0021, 32'h0, 1'b1);
        exp_ops++;
        cmd_op = RD2; cmd_rs1 = 5'd20; cmd_rs2 = 5'd1; cmd_rd = 5'd0; cmd_valid = 1'b1;
        sb_q.push_back({32'hBBDE0021, 32'hFFFFFFFF});
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", rsp_valid, 32'd1);
            chk("stall_rsp_data1", rsp_data1, 32'hBBDE0021);
            chk("stall_rsp_data2", rsp_data2, 32'h0);
            chk("stall_cmd_ready", cmd_ready, 32'd0);
            chk("stall_reg_write", reg_write, 32'd0);
            chk("stall_op_count", op_count, exp_ops - 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_stall_cmd_ready", cmd_ready, 32'd1);
        chk("post_stall_op_count", op_count, exp_ops);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("held_cmd_read_reg1", read_reg1, 32'd20);
        chk("held_cmd_reg_write", reg_write, 32'd0);
        repeat (2) @(negedge clk);
        chk("held_cmd_idle", cmd_ready, 32'd1);
        exp_ops++;
        chk("op_count_16", op_count, exp_ops);

        // Reset during EXEC of WRITE r9 aborts it with no write and no response.
        @(negedge clk);
        cmd_op = WR; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0; cmd_rd = 5'd9; cmd_wdata = 32'h12345678;
        cmd_valid = 1'b1;
        wc0 = wr_count;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_reg_write", reg_write, 32'd0);
        chk("abort_cmd_ready", cmd_ready, 32'd0);
        chk("abort_rsp_valid", rsp_valid, 32'd0);
        @(negedge clk);
        chk("abort_op_count", op_count, 32'd0);
        chk("abort_write_reg", write_reg, 32'd0);
        chk("abort_read_reg1", read_reg1, 32'd0);
        chk("abort_write_data", write_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_no_write", wr_count - wc0, 32'd0);
        chk("abort_idle", cmd_ready, 32'd1);
        chk("abort_no_rsp", rsp_valid, 32'd0);
        exp_ops = 0;
        run(RD2, 5'd9, 5'd0, 5'd0, 32'h0, 32'h10000009, 32'h0, 1'b0);
        chk("op_count_after_reset", op_count, exp_ops);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
